// File: rtl/full_adder_if.sv
// Operand/result bundle for the registered ripple adder.
// FULL_ADDER_OVF_EN adds the registered signed-overflow flag ovf.
interface full_adder_if #(
    parameter int WIDTH = 1
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             carry;
`ifdef FULL_ADDER_OVF_EN
    logic             ovf;

    modport master (output in_valid, a, b, cin, input out_valid, sum, carry, ovf);
    modport slave  (input in_valid, a, b, cin, output out_valid, sum, carry, ovf);
`else
    modport master (output in_valid, a, b, cin, input out_valid, sum, carry);
    modport slave  (input in_valid, a, b, cin, output out_valid, sum, carry);
`endif
endinterface

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder, one result per valid strobe, 1-cycle latency.
// Optional FULL_ADDER_OVF_EN registers two's-complement overflow next to the sum.
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    full_adder_if.slave  bus
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = bus.cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic p;
        assign p      = bus.a[i] ^ bus.b[i];
        assign s[i]   = p ^ c[i];
        assign c[i+1] = (bus.a[i] & bus.b[i]) | (c[i] & p);
    end

    logic [WIDTH-1:0] sum_d, sum_q;
    logic             carry_d, carry_q;
    logic             out_valid_d, out_valid_q;
`ifdef FULL_ADDER_OVF_EN
    logic             ovf_d, ovf_q;
`endif

    // Results only load on a strobe; otherwise they hold so X on idle inputs never reaches the flops.
    always_comb begin
        sum_d       = sum_q;
        carry_d     = carry_q;
        out_valid_d = 1'b0;
`ifdef FULL_ADDER_OVF_EN
        ovf_d       = ovf_q;
`endif
        if (bus.in_valid) begin
            sum_d       = s;
            carry_d     = c[WIDTH];
            out_valid_d = 1'b1;
`ifdef FULL_ADDER_OVF_EN
            ovf_d       = c[WIDTH] ^ c[WIDTH-1];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef FULL_ADDER_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
`ifdef FULL_ADDER_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign bus.sum       = sum_q;
    assign bus.carry     = carry_q;
    assign bus.out_valid = out_valid_q;
`ifdef FULL_ADDER_OVF_EN
    assign bus.ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder at WIDTH=1 and WIDTH=8, run side by side on one clock.
module tb_full_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    full_adder_if #(.WIDTH(1)) bus1 ();
    full_adder_if #(.WIDTH(8)) bus8 ();

    full_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    full_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    int tests = 0;
    int fails = 0;

    // Reference state: what the registered outputs must be after each edge.
    logic       model_ok = 1'b0;
    logic [0:0] m1_sum;
    logic       m1_carry, m1_vld, m1_ovf;
    logic [7:0] m8_sum;
    logic       m8_carry, m8_vld, m8_ovf;

    // Hand-computed expectations for the outputs visible in the current cycle.
    logic       p1_en = 1'b0, p1_vld, p1_sum, p1_carry;
    logic       p8_en = 1'b0, p8_vld, p8_carry, p8_ovf;
    logic [7:0] p8_sum;

    function automatic logic signed_ovf(int w, longint a, longint b, longint ci);
        longint sa, sb, tot;
        sa  = (a >= (64'sd1 <<< (w - 1))) ? a - (64'sd1 <<< w) : a;
        sb  = (b >= (64'sd1 <<< (w - 1))) ? b - (64'sd1 <<< w) : b;
        tot = sa + sb + ci;
        return (tot > (64'sd1 <<< (w - 1)) - 1) || (tot < -(64'sd1 <<< (w - 1)));
    endfunction

    always @(posedge clk) begin
        longint t1, t8;
        model_ok <= 1'b1;
        if (rst) begin
            {m1_sum, m1_carry, m1_vld, m1_ovf} <= '0;
            {m8_sum, m8_carry, m8_vld, m8_ovf} <= '0;
        end else begin
            m1_vld <= bus1.in_valid;
            m8_vld <= bus8.in_valid;
            if (bus1.in_valid) begin
                t1 = longint'(bus1.a) + longint'(bus1.b) + longint'(bus1.cin);
                m1_sum   <= t1 % 2;
                m1_carry <= (t1 >= 2);
                m1_ovf   <= signed_ovf(1, longint'(bus1.a), longint'(bus1.b), longint'(bus1.cin));
            end
            if (bus8.in_valid) begin
                t8 = longint'(bus8.a) + longint'(bus8.b) + longint'(bus8.cin);
                m8_sum   <= 8'(t8 % 256);
                m8_carry <= (t8 >= 256);
                m8_ovf   <= signed_ovf(8, longint'(bus8.a), longint'(bus8.b), longint'(bus8.cin));
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            chk("w1_vld",   64'(bus1.out_valid), 64'(m1_vld));
            chk("w1_sum",   64'(bus1.sum),       64'(m1_sum));
            chk("w1_carry", 64'(bus1.carry),     64'(m1_carry));
            chk("w8_vld",   64'(bus8.out_valid), 64'(m8_vld));
            chk("w8_sum",   64'(bus8.sum),       64'(m8_sum));
            chk("w8_carry", 64'(bus8.carry),     64'(m8_carry));
`ifdef FULL_ADDER_OVF_EN
            chk("w1_ovf",   64'(bus1.ovf),       64'(m1_ovf));
            chk("w8_ovf",   64'(bus8.ovf),       64'(m8_ovf));
`endif
        end
        if (p1_en) begin
            chk("pin1_vld",   64'(bus1.out_valid), 64'(p1_vld));
            chk("pin1_sum",   64'(bus1.sum),       64'(p1_sum));
            chk("pin1_carry", 64'(bus1.carry),     64'(p1_carry));
            chk("pin1_model", 64'({m1_vld, m1_sum, m1_carry}), 64'({p1_vld, p1_sum, p1_carry}));
        end
        if (p8_en) begin
            chk("pin8_vld",   64'(bus8.out_valid), 64'(p8_vld));
            chk("pin8_sum",   64'(bus8.sum),       64'(p8_sum));
            chk("pin8_carry", 64'(bus8.carry),     64'(p8_carry));
            chk("pin8_model", 64'({m8_vld, m8_sum, m8_carry, m8_ovf}),
                              64'({p8_vld, p8_sum, p8_carry, p8_ovf}));
`ifdef FULL_ADDER_OVF_EN
            chk("pin8_ovf",   64'(bus8.ovf),       64'(p8_ovf));
`endif
        end
    end

    // Advance to just after the next rising edge; pins describe that edge's results.
    task automatic nxt();
        @(posedge clk);
        #2;
        p1_en = 1'b0;
        p8_en = 1'b0;
    endtask

    task automatic pin1(input logic v, input logic s, input logic c);
        p1_en = 1'b1; p1_vld = v; p1_sum = s; p1_carry = c;
    endtask

    task automatic pin8(input logic v, input logic [7:0] s, input logic c, input logic o);
        p8_en = 1'b1; p8_vld = v; p8_sum = s; p8_carry = c; p8_ovf = o;
    endtask

    task automatic drv1(input logic v, input logic a, input logic b, input logic ci);
        bus1.in_valid = v; bus1.a = a; bus1.b = b; bus1.cin = ci;
    endtask

    task automatic drv8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic ci);
        bus8.in_valid = v; bus8.a = a; bus8.b = b; bus8.cin = ci;
    endtask

    initial begin
        drv1(1'b0, 1'b0, 1'b0, 1'b0);
        drv8(1'b0, 8'h00, 8'h00, 1'b0);
        rst = 1'b1;
        nxt();
        pin1(0, 0, 0); pin8(0, 8'h00, 0, 0);
        nxt();
        pin1(0, 0, 0); pin8(0, 8'h00, 0, 0);
        rst = 1'b0;
        nxt();
        // first idle cycle after release
        pin1(0, 0, 0); pin8(0, 8'h00, 0, 0);
        drv1(1, 0, 0, 0); drv8(1, 8'h7F, 8'h01, 0);
        nxt();
        pin1(1, 0, 0); pin8(1, 8'h80, 0, 1);
        drv1(1, 0, 1, 1); drv8(1, 8'hFF, 8'h00, 1);
        nxt();
        pin1(1, 0, 1); pin8(1, 8'h00, 1, 0);
        drv1(1, 1, 0, 1); drv8(1, 8'hFF, 8'hFF, 1);
        nxt();
        pin1(1, 0, 1); pin8(1, 8'hFF, 1, 0);
        drv1(1, 1, 1, 0); drv8(1, 8'h00, 8'h00, 0);
        nxt();
        pin1(1, 0, 1); pin8(1, 8'h00, 0, 0);
        drv1(1, 1, 0, 0); drv8(1, 8'h80, 8'h80, 0);
        nxt();
        pin1(1, 1, 0); pin8(1, 8'h00, 1, 1);
        drv1(1, 1, 1, 1); drv8(1, 8'h12, 8'h34, 1);
        nxt();
        pin1(1, 1, 1); pin8(1, 8'h47, 0, 0);
        // idle with toggling / unknown inputs: outputs must hold
        drv1(0, 0, 1, 1'bx); drv8(0, 8'hxx, 8'h55, 1);
        nxt();
        pin1(0, 1, 1); pin8(0, 8'h47, 0, 0);
        drv1(0, 1, 0, 0); drv8(0, 8'hAA, 8'hxx, 0);
        nxt();
        pin1(0, 1, 1); pin8(0, 8'h47, 0, 0);
        drv1(0, 1'bx, 1'bx, 1); drv8(0, 8'hFF, 8'hFF, 1'bx);
        nxt();
        pin1(0, 1, 1); pin8(0, 8'h47, 0, 0);
        // all eight 1-bit combinations back to back, model-checked
        for (int i = 0; i < 8; i++) begin
            drv1(1, i[2], i[1], i[0]);
            drv8(1, 8'($urandom), 8'($urandom), 1'($urandom));
            nxt();
        end
        // reset beats a valid strobe on the same edge
        drv1(1, 1, 1, 1); drv8(1, 8'hFF, 8'hFF, 1);
        rst = 1'b1;
        nxt();
        pin1(0, 0, 0); pin8(0, 8'h00, 0, 0);
        rst = 1'b0;
        drv1(0, 1, 1, 1); drv8(0, 8'hFF, 8'hFF, 1);
        nxt();
        pin1(0, 0, 0); pin8(0, 8'h00, 0, 0);
        // mixed valid/idle random traffic
        for (int i = 0; i < 40; i++) begin
            drv1(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            drv8(bus1.in_valid, 8'($urandom), 8'($urandom), 1'($urandom));
            nxt();
        end
        drv1(0, 0, 0, 0); drv8(0, 8'h00, 8'h00, 0);
        nxt();
        nxt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
